sram_controller: RTL and testbench

//  Bridges the pipeline's memory stage to the off-chip 16-bit asynchronous SRAM. Each 32-bit

---
 rtl/sram_controller.sv | 94 +++++++++
 tb/tb_sram_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Bridges 32-bit CPU loads/stores to a 16-bit asynchronous SRAM as two half-word accesses
// (low half, then high half) followed by a fixed recovery wait.
module sram_controller #(
    parameter int          WAIT_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_WAIT, S_DONE} state_t;

    state_t             state, state_nxt;
    logic               op_wr;
    logic [SRAM_AW-2:0] word;
    logic [31:0]        wdata;
    logic [CW-1:0]      wait_cnt;
    logic [31:0]        phys;
    logic               accept;
    logic               in_xfer;
    logic               is_hi;
    logic               unused_phys;

    // Subtraction wraps modulo 2^32, so addresses below BASE_ADDR alias to the top of SRAM.
    assign phys        = address - BASE_ADDR;
    assign unused_phys = ^{phys[31:SRAM_AW+1], phys[1:0]};
    assign accept      = (state == S_IDLE) && (wr_en || rd_en);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_LO;
            S_LO:   state_nxt = S_HI;
            S_HI:   state_nxt = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
            S_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            op_wr    <= 1'b0;
            word     <= '0;
            wdata    <= '0;
            wait_cnt <= '0;
            readData <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_wr <= wr_en;
                word  <= phys[SRAM_AW:2];
                wdata <= writeData;
            end
            if (state == S_WAIT)
                wait_cnt <= (wait_cnt == WAIT_LAST) ? '0 : wait_cnt + 1'b1;
            if (state == S_LO && !op_wr)
                readData[15:0] <= SRAM_DQ;
            if (state == S_HI && !op_wr)
                readData[31:16] <= SRAM_DQ;
        end
    end

    assign in_xfer   = (state == S_LO) || (state == S_HI);
    assign is_hi     = (state == S_HI);
    assign SRAM_ADDR = {word, is_hi};
    assign SRAM_WE_N = ~(in_xfer & op_wr);
    assign SRAM_OE_N = ~(in_xfer & ~op_wr);
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = (in_xfer && op_wr) ? (is_hi ? wdata[31:16] : wdata[15:0]) : 16'hzzzz;

    assign ready = ((state == S_IDLE) && !rd_en && !wr_en) || (state == S_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: table of 32-bit transfers against a behavioural SRAM, plus
// sequences for reset, mid-transfer request changes, back-to-back requests and WAIT_CYCLES=0.
module tb_sram_controller;

    localparam int LAT = 4 + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] readData, readData0;
    logic        ready, ready0;
    wire  [15:0] SRAM_DQ;
    wire  [15:0] dq0;
    logic [17:0] SRAM_ADDR, addr0;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;
    logic        we_n0, oe_n0, ce_n0, ub_n0, lb_n0;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .writeData(writeData), .readData(readData), .ready(ready), .SRAM_DQ(SRAM_DQ),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    sram_controller #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .writeData(writeData), .readData(readData0), .ready(ready0), .SRAM_DQ(dq0),
        .SRAM_ADDR(addr0), .SRAM_WE_N(we_n0), .SRAM_OE_N(oe_n0), .SRAM_CE_N(ce_n0),
        .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0)
    );

    // Behavioural SRAM plus a bench-controlled probe driver used while the controller must float DQ.
    logic [15:0] mem [0:262143];
    logic        probe_en = 1'b0;
    localparam logic [15:0] PROBE = 16'hA5C3;

    assign SRAM_DQ = (!oe_n && we_n) ? mem[SRAM_ADDR] : 16'hzzzz;
    assign SRAM_DQ = probe_en ? PROBE : 16'hzzzz;
    always @(posedge clk) if (!we_n) mem[SRAM_ADDR] <= SRAM_DQ;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] rdata;
        logic [31:0] lat;
    } sb_t;
    sb_t sb[$];

    typedef struct packed {
        logic        w;
        logic        r;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] lo_addr;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[12];

    task automatic run_xfer(input logic w, input logic r, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd, input int hold,
                            input bit keep, output int lat0, output int strobes,
                            output logic [17:0] a_lo, output logic [17:0] a_hi, output int bad);
        sb_t e;
        int  lat;
        lat = -1; lat0 = -1; strobes = 0; bad = 0; a_lo = '0; a_hi = '0;
        @(negedge clk);
        wr_en = w; rd_en = r; address = a; writeData = d;
        sb.push_back('{rdata: exp_rd, lat: LAT});
        #1 chk("accept_ready_low", {31'b0, ready}, 32'd0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!we_n || !oe_n) begin
                if (strobes == 0) a_lo = SRAM_ADDR; else a_hi = SRAM_ADDR;
                strobes++;
                if (we_n == w || oe_n == !w) bad++;
            end
            if (ready0 && lat0 < 0) lat0 = c;
            if (ready) begin
                lat = c;
                break;
            end
            if (c == hold) begin
                wr_en = 1'b0; rd_en = 1'b0; address = 32'h0BAD_0000; writeData = '0;
            end
        end
        if (!keep) begin
            wr_en = 1'b0; rd_en = 1'b0;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("latency", lat, e.lat);
            chk("read_data", readData, e.rdata);
        end
    endtask

    initial begin
        int          lat0, strobes, bad;
        logic [17:0] a_lo, a_hi;

        vecs[0]  = '{1'b1, 1'b0, 32'd1028,      32'hDEADBEEF, 18'd2,      32'h00000000};
        vecs[1]  = '{1'b0, 1'b1, 32'd1028,      32'hFFFFFFFF, 18'd2,      32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'd1024,      32'h12345678, 18'd0,      32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b0, 32'd263164,    32'hCAFEF00D, 18'd131070, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'd263164,    32'h0,        18'd131070, 32'hCAFEF00D};
        vecs[5]  = '{1'b1, 1'b0, 32'd1022,      32'hA5A55A5A, 18'd262142, 32'hCAFEF00D};
        vecs[6]  = '{1'b0, 1'b1, 32'd1022,      32'h0,        18'd262142, 32'hA5A55A5A};
        vecs[7]  = '{1'b0, 1'b1, 32'd1024,      32'h0,        18'd0,      32'h12345678};
        vecs[8]  = '{1'b1, 1'b0, 32'd1029,      32'h11112222, 18'd2,      32'h12345678};
        vecs[9]  = '{1'b0, 1'b1, 32'd1030,      32'h0,        18'd2,      32'h11112222};
        vecs[10] = '{1'b1, 1'b0, 32'h0008_0404, 32'h9ABCDEF0, 18'd2,      32'h11112222};
        vecs[11] = '{1'b0, 1'b1, 32'd1028,      32'h0,        18'd2,      32'h9ABCDEF0};

        for (int i = 0; i < 262144; i++) mem[i] = '0;

        // Reset held for three cycles
        probe_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_readData", readData, 32'd0);
        chk("rst_we_n", {31'b0, we_n}, 32'd1);
        chk("rst_oe_n", {31'b0, oe_n}, 32'd1);
        chk("rst_dq_released", {16'b0, SRAM_DQ}, {16'b0, PROBE});
        chk("rst_addr", {14'b0, SRAM_ADDR}, 32'd0);
        chk("rst_tied", {29'b0, ce_n, ub_n, lb_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'b0, ready}, 32'd1);
        chk("post_rst_we_n", {31'b0, we_n}, 32'd1);
        probe_en = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_xfer(vecs[i].w, vecs[i].r, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
                     99, 1'b0, lat0, strobes, a_lo, a_hi, bad);
            chk($sformatf("v%0d_strobes", i), strobes, 32'd2);
            chk($sformatf("v%0d_lo_addr", i), {14'b0, a_lo}, {14'b0, vecs[i].lo_addr});
            chk($sformatf("v%0d_hi_addr", i), {14'b0, a_hi}, {14'b0, vecs[i].lo_addr | 18'd1});
            chk($sformatf("v%0d_strobe_kind", i), bad, 32'd0);
            chk($sformatf("v%0d_lat_wait0", i), lat0, 32'd3);
            if (vecs[i].w) begin
                chk($sformatf("v%0d_mem_lo", i), {16'b0, mem[vecs[i].lo_addr]},
                    {16'b0, vecs[i].wdata[15:0]});
                chk($sformatf("v%0d_mem_hi", i), {16'b0, mem[vecs[i].lo_addr | 18'd1]},
                    {16'b0, vecs[i].wdata[31:16]});
            end
            @(negedge clk);
            chk($sformatf("v%0d_back_to_idle", i), {31'b0, ready}, 32'd1);
        end

        // Request dropped and address changed right after acceptance: latched write completes
        run_xfer(1'b1, 1'b0, 32'd1032, 32'h0BADF00D, 32'h9ABCDEF0, 1, 1'b0,
                 lat0, strobes, a_lo, a_hi, bad);
        chk("drop_strobes", strobes, 32'd2);
        chk("drop_mem_lo", {16'b0, mem[4]}, 32'h0000F00D);
        chk("drop_mem_hi", {16'b0, mem[5]}, 32'h00000BAD);
        repeat (2) @(negedge clk);

        // Request still held after DONE starts a fresh transfer
        run_xfer(1'b0, 1'b1, 32'd1024, 32'h0, 32'h12345678, 99, 1'b1,
                 lat0, strobes, a_lo, a_hi, bad);
        @(negedge clk);
        chk("restart_ready_low", {31'b0, ready}, 32'd0);
        @(negedge clk);
        chk("restart_oe_n", {31'b0, oe_n}, 32'd0);
        chk("restart_addr", {14'b0, SRAM_ADDR}, 32'd0);
        rd_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("restart_readData", readData, 32'h12345678);
        chk("restart_idle", {31'b0, ready}, 32'd1);

        // Reset asserted during the HI half of a write
        wr_en = 1'b1; address = 32'd1024; writeData = 32'h77778888;
        @(negedge clk);
        chk("midrst_lo_we", {31'b0, we_n}, 32'd0);
        @(negedge clk);
        chk("midrst_hi_we", {31'b0, we_n}, 32'd0);
        chk("midrst_hi_addr", {14'b0, SRAM_ADDR}, 32'd1);
        rst = 1'b0; wr_en = 1'b0; probe_en = 1'b1;
        #1;
        chk("midrst_we_n", {31'b0, we_n}, 32'd1);
        chk("midrst_dq_released", {16'b0, SRAM_DQ}, {16'b0, PROBE});
        chk("midrst_ready", {31'b0, ready}, 32'd1);
        repeat (2) @(negedge clk);
        chk("midrst_mem_hi_kept", {16'b0, mem[1]}, 32'h00001234);
        rst = 1'b1; probe_en = 1'b0;
        @(negedge clk);
        chk("midrst_idle", {31'b0, ready}, 32'd1);
        run_xfer(1'b0, 1'b1, 32'd1024, 32'h0, 32'h12348888, 99, 1'b0,
                 lat0, strobes, a_lo, a_hi, bad);
        chk("midrst_read_strobes", strobes, 32'd2);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
